// File: rtl/egress_ctrl.sv
// Egress metadata buffer: crossbar words go into external SDP memory and are replayed to the interface in order.
// Latency: a write from empty shows out_valid 3 cycles later; sustained rate is one word every 2 cycles.
// Backpressure: out_ready=0 holds the word steady; writes arriving while full are dropped and counted.
module egress_ctrl #(
    parameter int PACKET_CNT = 1024,
    parameter int META_WIDTH = 32,
    parameter int AF_MARGIN  = 4,
    localparam int AW        = $clog2(PACKET_CNT)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  wr_req,
    input  logic [META_WIDTH-1:0] wr_data,
    output logic                  mem_we,
    output logic [AW-1:0]         mem_wa,
    output logic [META_WIDTH-1:0] mem_d,
    output logic [AW-1:0]         mem_ra,
    input  logic [META_WIDTH-1:0] mem_q,
    output logic                  out_valid,
    output logic [META_WIDTH-1:0] out_data,
    input  logic                  out_ready,
    output logic                  full,
    output logic                  almost_full,
    output logic [AW:0]           count,
    output logic [15:0]           drop_cnt
);

    localparam logic [AW:0]   CNT_FULL = (AW+1)'(PACKET_CNT);
    localparam logic [AW:0]   CNT_AF   = (AW+1)'(PACKET_CNT - AF_MARGIN);
    localparam logic [AW:0]   CNT_ONE  = (AW+1)'(1);
    localparam logic [AW-1:0] IDX_ONE  = AW'(1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        HOLD  = 2'd2
    } rd_state_t;

    rd_state_t     state;
    logic [AW-1:0] wr_idx;
    logic [AW-1:0] rd_idx;
    logic          wr_acc;
    logic          wr_drop;
    logic          pop;

    // Flags decode the registered count only, so wr_req/out_ready never reach full/almost_full.
    assign full        = (count == CNT_FULL);
    assign almost_full = (count >= CNT_AF);

    // Write admission uses the pre-pop count: a pop in the same cycle does not make room.
    assign wr_acc  = reset & wr_req & ~full;
    assign wr_drop = reset & wr_req & full;
    assign pop     = (state == HOLD) & out_ready;

    assign mem_we = wr_acc;
    assign mem_wa = wr_idx;
    assign mem_d  = wr_data;
    // Read address is always the head; the held word stays counted so it cannot be overwritten.
    assign mem_ra = rd_idx;

    // Pointers and occupancy; pointers wrap naturally at the power-of-two depth.
    always_ff @(posedge clk) begin
        if (!reset) begin
            wr_idx <= '0;
            rd_idx <= '0;
            count  <= '0;
        end else begin
            if (wr_acc)
                wr_idx <= wr_idx + IDX_ONE;
            if (pop)
                rd_idx <= rd_idx + IDX_ONE;
            case ({wr_acc, pop})
                2'b10:   count <= count + CNT_ONE;
                2'b01:   count <= count - CNT_ONE;
                default: count <= count;
            endcase
        end
    end

    // Saturating counter of writes rejected because the buffer was full.
    always_ff @(posedge clk) begin
        if (!reset) begin
            drop_cnt <= '0;
        end else if (wr_drop && (drop_cnt != 16'hFFFF)) begin
            drop_cnt <= drop_cnt + 16'd1;
        end
    end

    // Read FSM: FETCH waits a cycle for mem_q at the head address, HOLD presents it until accepted.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state     <= IDLE;
            out_valid <= 1'b0;
            out_data  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    out_valid <= 1'b0;
                    if (count != '0)
                        state <= FETCH;
                end
                FETCH: begin
                    out_data  <= mem_q;
                    out_valid <= 1'b1;
                    state     <= HOLD;
                end
                HOLD: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        state     <= (count > CNT_ONE) ? FETCH : IDLE;
                    end
                end
                default: begin
                    out_valid <= 1'b0;
                    state     <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_egress_ctrl.sv
// Bench for egress_ctrl: directed scenarios plus randomized traffic against a queue-based model.
// Latency: first-word timing checked explicitly; every cycle compares occupancy, flags and data.
// Backpressure: out_ready is held low, toggled and randomized; drops are modelled.
module tb_egress_ctrl;

    localparam int PC = 1024;
    localparam int MW = 32;
    localparam int AW = 10;
    localparam int AFM = 4;

    logic          clk = 1'b0;
    logic          reset;
    logic          wr_req;
    logic [MW-1:0] wr_data;
    logic          mem_we;
    logic [AW-1:0] mem_wa;
    logic [MW-1:0] mem_d;
    logic [AW-1:0] mem_ra;
    logic [MW-1:0] mem_q;
    logic          out_valid;
    logic [MW-1:0] out_data;
    logic          out_ready;
    logic          full;
    logic          almost_full;
    logic [AW:0]   count;
    logic [15:0]   drop_cnt;

    always #5 clk = ~clk;

    egress_ctrl #(
        .PACKET_CNT (PC),
        .META_WIDTH (MW),
        .AF_MARGIN  (AFM)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .wr_req      (wr_req),
        .wr_data     (wr_data),
        .mem_we      (mem_we),
        .mem_wa      (mem_wa),
        .mem_d       (mem_d),
        .mem_ra      (mem_ra),
        .mem_q       (mem_q),
        .out_valid   (out_valid),
        .out_data    (out_data),
        .out_ready   (out_ready),
        .full        (full),
        .almost_full (almost_full),
        .count       (count),
        .drop_cnt    (drop_cnt)
    );

    // Simple dual-port memory: registered write, read data settled during the cycle after the address.
    logic [MW-1:0] mem [PC];
    always @(posedge clk) if (mem_we) mem[mem_wa] <= mem_d;
    assign mem_q = mem[mem_ra];

    int total = 0;
    int bad   = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Reference model: ordered queue of accepted words plus occupancy, drop and pointer counters.
    logic [MW-1:0] exp_q[$];
    int mcount = 0;
    int mdrop  = 0;
    int wp     = 0;
    int rp     = 0;

    always @(negedge clk) begin
        bit acc;
        bit pop;
        if (!reset) begin
            chk("we_in_reset", mem_we, 0);
            exp_q.delete();
            mcount = 0;
            mdrop  = 0;
            wp     = 0;
            rp     = 0;
        end else begin
            acc = wr_req && (mcount != PC);
            pop = out_valid && out_ready;
            chk("count", count, mcount);
            chk("full", full, mcount == PC);
            chk("almost_full", almost_full, mcount >= PC - AFM);
            chk("drop_cnt", drop_cnt, mdrop);
            chk("mem_ra", mem_ra, rp);
            chk("mem_we", mem_we, acc);
            if (acc) begin
                chk("mem_wa", mem_wa, wp);
                chk("mem_d", mem_d, wr_data);
            end
            if (out_valid)
                chk("valid_nonempty", mcount > 0, 1);
            if (pop) begin
                chk("pop_nonempty", exp_q.size() > 0, 1);
                if (exp_q.size() > 0)
                    chk("out_data", out_data, exp_q.pop_front());
                rp = (rp + 1) % PC;
            end
            if (acc) begin
                exp_q.push_back(wr_data);
                wp = (wp + 1) % PC;
            end
            if (wr_req && (mcount == PC) && (mdrop != 65535))
                mdrop++;
            mcount = mcount + int'(acc) - int'(pop);
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drain(input string tag);
        int n = 0;
        wr_req    = 1'b0;
        out_ready = 1'b1;
        while ((count != 0 || out_valid) && n < 4000) begin
            step();
            n++;
        end
        chk(tag, (count == 0) && !out_valid, 1);
        out_ready = 1'b0;
    endtask

    task automatic wait_valid(input string tag);
        int n = 0;
        while (!out_valid && n < 50) begin
            step();
            n++;
        end
        chk(tag, out_valid, 1);
    endtask

    initial begin
        int  n;
        int  lat;
        bit  seen;

        reset     = 1'b0;
        wr_req    = 1'b0;
        wr_data   = '0;
        out_ready = 1'b0;
        repeat (3) step();
        chk("rst_count", count, 0);
        chk("rst_valid", out_valid, 0);
        chk("rst_data", out_data, 0);
        chk("rst_full", full, 0);
        chk("rst_af", almost_full, 0);
        chk("rst_drop", drop_cnt, 0);
        reset = 1'b1;
        step();

        // Three back-to-back words with out_ready high; first out_valid 3 cycles after first wr_req.
        out_ready = 1'b1;
        n = 0; lat = 0; seen = 1'b0;
        for (int i = 0; i < 3; i++) begin
            wr_req  = 1'b1;
            wr_data = 32'hA5A5_0001 + i;
            step();
            n++;
            if (!seen && out_valid) begin seen = 1'b1; lat = n; end
        end
        wr_req = 1'b0;
        while (!seen && n < 20) begin
            step();
            n++;
            if (out_valid) begin seen = 1'b1; lat = n; end
        end
        chk("first_latency", lat, 3);
        drain("drain_basic");
        chk("idle_valid", out_valid, 0);
        chk("idle_count", count, 0);

        // Held word stays stable for 10 cycles of backpressure.
        out_ready = 1'b0;
        wr_req    = 1'b1;
        wr_data   = 32'hBEEF_0041;
        step();
        wr_req = 1'b0;
        wait_valid("hold_reach");
        for (int i = 0; i < 10; i++) begin
            step();
            chk("hold_data", out_data, 32'hBEEF_0041);
            chk("hold_valid", out_valid, 1);
            chk("hold_count", count, 1);
        end
        drain("drain_hold");

        // Fill to capacity with no reads; check almost_full threshold and full.
        out_ready = 1'b0;
        for (int i = 0; i < PC; i++) begin
            wr_req  = 1'b1;
            wr_data = $urandom;
            step();
            if (i + 1 == PC - AFM - 1) chk("af_below", almost_full, 0);
            if (i + 1 == PC - AFM) begin
                chk("af_at", almost_full, 1);
                chk("full_early", full, 0);
            end
        end
        chk("full_set", full, 1);
        chk("full_count", count, PC);
        for (int i = 0; i < 5; i++) begin
            wr_req  = 1'b1;
            wr_data = $urandom;
            #1;
            chk("we_when_full", mem_we, 0);
            step();
        end
        wr_req = 1'b0;
        chk("drop_five", drop_cnt, 5);

        // Full with simultaneous write and pop: write dropped, one word leaves.
        wr_req    = 1'b1;
        wr_data   = 32'hDEAD_0039;
        out_ready = 1'b1;
        step();
        wr_req    = 1'b0;
        out_ready = 1'b0;
        chk("drop_on_pop", drop_cnt, 6);
        chk("count_on_pop", count, PC - 1);
        drain("drain_full");

        // Half-rate push with out_ready high; pointers wrap past the end of memory.
        for (int c = 0; c < 2060; c++) begin
            wr_req    = (c % 2 == 0);
            wr_data   = 32'hC000_0000 + c;
            out_ready = 1'b1;
            step();
        end
        drain("drain_half");

        // Randomized traffic with random backpressure.
        for (int c = 0; c < 4000; c++) begin
            wr_req    = ($urandom % 4) != 0;
            wr_data   = $urandom;
            out_ready = $urandom_range(0, 1);
            step();
        end
        drain("drain_rand");

        // Reset with 7 words buffered discards them; a new word emerges first.
        out_ready = 1'b0;
        for (int i = 0; i < 7; i++) begin
            wr_req  = 1'b1;
            wr_data = 32'h7700_0000 + i;
            step();
        end
        wr_req = 1'b0;
        step();
        chk("pre_rst_count", count, 7);
        reset = 1'b0;
        step();
        reset = 1'b1;
        chk("mid_rst_count", count, 0);
        chk("mid_rst_valid", out_valid, 0);
        chk("mid_rst_drop", drop_cnt, 0);
        chk("mid_rst_data", out_data, 0);
        wr_req  = 1'b1;
        wr_data = 32'h0000_1234;
        step();
        wr_req = 1'b0;
        wait_valid("post_rst_valid");
        chk("post_rst_data", out_data, 32'h0000_1234);
        drain("drain_final");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/egress_ctrl.md
EGRESS_CTRL -- requirements
Module: egress_ctrl

Interface
REQ-001 Parameter PACKET_CNT, default 1024, meaning entries in the egress metadata memory (power of 2, AW = log2(PACKET_CNT)).
REQ-002 Parameter META_WIDTH, default 32, meaning metadata word width.
REQ-003 Parameter AF_MARGIN, default 4, meaning free-entry threshold for almost-full.
REQ-004 clk  input  1  single clock; all logic on rising edge.
REQ-005 reset  input  1  synchronous, active-low reset (asserted when 0).
REQ-006 wr_req  input  1  crossbar delivers one metadata word this cycle.
REQ-007 wr_data  input  META_WIDTH  metadata word from crossbar.
REQ-008 mem_we  output  1  write enable to simple dual-port memory.
REQ-009 mem_wa  output  AW  memory write address.
REQ-010 mem_d  output  META_WIDTH  memory write data.
REQ-011 mem_ra  output  AW  memory read address.
REQ-012 mem_q  input  META_WIDTH  memory read data, valid one cycle after mem_ra.
REQ-013 out_valid  output  1  out_data holds a word for the interface.
REQ-014 out_data  output  META_WIDTH  word to interface.
REQ-015 out_ready  input  1  interface accepts out_data this cycle.
REQ-016 full  output  1  occupancy == PACKET_CNT.
REQ-017 almost_full  output  1  occupancy >= PACKET_CNT - AF_MARGIN.
REQ-018 count  output  AW+1  current occupancy.
REQ-019 drop_cnt  output  16  writes rejected while full.

Function
REQ-020 Write pointer wr_idx and read pointer rd_idx SHALL each be AW bits, incrementing by 1 and wrapping PACKET_CNT-1 -> 0.
REQ-021 Write accepted iff wr_req=1 and full=0 in the same cycle; then mem_we=1, mem_wa=wr_idx, mem_d=wr_data (combinational), wr_idx and count update next edge.
REQ-022 wr_req=1 with full=1: mem_we=0, no pointer change, drop_cnt +1, saturating at 0xFFFF.
REQ-023 full and almost_full SHALL be registered-state decodes of count (no combinational path from wr_req or out_ready).
REQ-024 Read FSM states: IDLE, FETCH, HOLD; mem_ra=rd_idx at all times.
REQ-025 IDLE: out_valid=0; if count>0 go to FETCH.
REQ-026 FETCH: out_valid=0; next edge capture mem_q into out_data, go to HOLD.
REQ-027 HOLD: out_valid=1, out_data stable; on out_ready=1: rd_idx +1 (wrap), count -1, then FETCH if count-1 > 0 else IDLE; on out_ready=0 stay.
REQ-028 A word occupies count until accepted in HOLD; it is never overwritten while held.
REQ-029 Simultaneous accepted write and pop: count unchanged, both pointers advance.
REQ-030 Pop when full with wr_req=1: write is dropped (full evaluated on pre-pop count), count becomes PACKET_CNT-1.
REQ-031 Word written at edge t is eligible for FETCH from edge t+1; first-word latency wr_req -> out_valid = 3 cycles from empty.
REQ-032 Sustained throughput SHALL be one word per 2 cycles with out_ready held high.
REQ-033 count arithmetic SHALL use AW+1 bits; never exceeds PACKET_CNT nor goes below 0.

Reset
REQ-034 While reset=0 at a rising edge: wr_idx=0, rd_idx=0, count=0, drop_cnt=0, FSM=IDLE, out_data=0, out_valid=0, full=0, almost_full=0 next cycle.
REQ-035 Reset mid-operation discards all buffered words and any held out_data; mem_we=0 while reset=0.
REQ-036 Memory contents are not cleared; correctness relies only on pointers.

Verification
REQ-037 Write 0xA5A5_0001..0xA5A5_0003 back-to-back, out_ready=1 -> out_data in same order, first out_valid 3 cycles after first wr_req, count returns to 0, FSM IDLE.
REQ-038 Fill 1024 words, out_ready=0 -> full=1 at count=1024, almost_full=1 from count=1020; 5 further wr_req -> drop_cnt=5, mem_we=0.
REQ-039 Full state, assert wr_req and out_ready same cycle -> write dropped, drop_cnt +1, count=1023.
REQ-040 Push/pop 1030 words at half rate -> wr_idx and rd_idx wrap 1023->0, data in order, no loss.
REQ-041 out_ready=0 for 10 cycles in HOLD -> out_data stable, out_valid=1, count unchanged.
REQ-042 reset=0 for one cycle with 7 words buffered -> count=0, out_valid=0, drop_cnt=0; next write 0x1234 emerges first.
